// File: rtl/c_join_4ph_if.sv
// Handshake/data bundle between parallel producers, the join and its consumer.
// master = producer/consumer side, slave = the join itself.
interface c_join_4ph_if #(
  parameter int NCH = 2,
  parameter int DW  = 8
);
  logic [NCH-1:0]    en_mask;
  logic [NCH-1:0]    in_req;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ack;
  logic              out_req;
  logic [NCH*DW-1:0] out_data;
  logic              out_ack;

  modport master (
    output en_mask, in_req, in_data, out_ack,
    input  in_ack, out_req, out_data
  );

  modport slave (
    input  en_mask, in_req, in_data, out_ack,
    output in_ack, out_req, out_data
  );
endinterface

// File: rtl/c_join_4ph.sv
// Clocked four-phase join: synchronous multi-input C-element with channel
// masking, data capture, sticky protocol-error flag and a transfer counter.
module c_join_4ph #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  c_join_4ph_if.slave   bus,
  input  logic          err_clr,
  output logic          err,
  output logic [CW-1:0] xfer_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    lmask_q, lmask_d;
  logic [NCH-1:0]    in_ack_q, in_ack_d;
  logic              out_req_q, out_req_d;
  logic [NCH*DW-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              viol;
  logic [NCH*DW-1:0] lane_mask;

  // Expand the live channel enables to one bit per data bit.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NCH; k++) begin
      lane_mask[k*DW +: DW] = {DW{bus.en_mask[k]}};
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    lmask_d   = lmask_q;
    in_ack_d  = in_ack_q;
    out_req_d = out_req_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    viol      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The mask is only latched here; the live enables decide the join.
        lmask_d = bus.en_mask;
        viol    = bus.out_ack & ~out_req_q;
        if ((|bus.en_mask) && (&(bus.in_req | ~bus.en_mask))) begin
          state_d   = REQ;
          out_req_d = 1'b1;
          data_d    = bus.in_data & lane_mask;
        end
      end
      REQ: begin
        viol = (|(lmask_q & ~bus.in_req)) | (bus.out_ack & ~out_req_q);
        if (bus.out_ack) begin
          state_d  = ACK;
          in_ack_d = lmask_q;
        end
      end
      ACK: begin
        if (!(|(bus.in_req & lmask_q))) begin
          state_d   = RTZ;
          out_req_d = 1'b0;
        end
      end
      RTZ: begin
        viol = |(bus.in_req & lmask_q);
        if (!bus.out_ack) begin
          state_d  = IDLE;
          in_ack_d = '0;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new violation outranks a coincident clear.
    if (viol)         err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lmask_q   <= '0;
      in_ack_q  <= '0;
      out_req_q <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lmask_q   <= lmask_d;
      in_ack_q  <= in_ack_d;
      out_req_q <= out_req_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ack   = in_ack_q;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = data_q;
  assign err          = err_q;
  assign xfer_cnt     = cnt_q;

endmodule
